// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for simple_fifo: drains BURST_LEN-word bursts onto an AXI4-Stream
// master, absorbing the FIFO read latency with a 2-entry buffer; flush pads a partial tail burst.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  m_tpad,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] LastIdx = CNT_WIDTH'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

  state_e               state_q, state_d;
  logic                 flush_mode_q, flush_mode_d;
  logic                 flush_latch_q, flush_latch_d;
  logic                 flush_done_q, flush_done_d;
  logic                 padding_q, padding_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] accepted_q, accepted_d;

  // In-flight stage: a FIFO read or pad beat issued last cycle, visible this cycle.
  logic                 infl_q, infl_d;
  logic                 infl_pad_q, infl_pad_d;
  logic                 infl_last_q, infl_last_d;
  logic [DATA_WIDTH-1:0] infl_word;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_last_q, buf_pad_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;

  logic       pop, pop_buf, push;
  logic [1:0] occ_after;
  logic       space, issue_ok, rd, pad, issue;

  assign infl_word = infl_pad_q ? '0 : fifo_rd_data;

  // Head is the oldest buffered entry, else the in-flight beat bypasses the buffer.
  always_comb begin
    m_tvalid = (count_q != 2'd0) | infl_q;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tpad   = 1'b0;
    if (count_q != 2'd0) begin
      m_tdata = buf_data_q[rd_ptr_q];
      m_tlast = buf_last_q[rd_ptr_q];
      m_tpad  = buf_pad_q[rd_ptr_q];
    end else if (infl_q) begin
      m_tdata = infl_word;
      m_tlast = infl_last_q;
      m_tpad  = infl_pad_q;
    end
  end

  assign pop     = m_tvalid & m_tready;
  assign pop_buf = pop & (count_q != 2'd0);
  assign push    = infl_q & ~(pop & (count_q == 2'd0));
  assign count_d = count_q + {1'b0, push} - {1'b0, pop_buf};

  // Space counts the beat leaving this cycle so a steady stream sustains 1 beat/clk.
  assign occ_after = count_q + {1'b0, infl_q} - {1'b0, pop};
  assign space     = occ_after < 2'd2;
  assign issue_ok  = (state_q == StBurst) & space;
  assign rd        = issue_ok & ~fifo_empty & ~padding_q;
  assign pad       = issue_ok & flush_mode_q & (padding_q | fifo_empty);
  assign issue     = rd | pad;

  assign fifo_rd_en = rd;
  assign flush_done = flush_done_q;
  assign busy       = (state_q != StIdle);

  always_comb begin
    state_d       = state_q;
    flush_mode_d  = flush_mode_q;
    flush_latch_d = flush_latch_q | flush_req;
    flush_done_d  = 1'b0;
    padding_d     = padding_q;
    issued_d      = issued_q + CNT_WIDTH'(issue);
    accepted_d    = accepted_q + CNT_WIDTH'(pop);
    infl_d        = issue;
    infl_pad_d    = pad;
    infl_last_d   = (issued_q == LastIdx);
    unique case (state_q)
      StIdle: begin
        issued_d   = '0;
        accepted_d = '0;
        padding_d  = 1'b0;
        if (!fifo_almost_empty) begin
          state_d      = StBurst;
          flush_mode_d = 1'b0;
        end else if (flush_latch_q && !fifo_empty) begin
          state_d      = StBurst;
          flush_mode_d = 1'b1;
        end else if (flush_latch_q) begin
          flush_done_d  = 1'b1;
          flush_latch_d = flush_req;
        end
      end
      StBurst: begin
        if (pad) padding_d = 1'b1;
        if (issue && issued_q == LastIdx) state_d = StDrain;
      end
      StDrain: begin
        if (pop && accepted_q == LastIdx) begin
          state_d = StIdle;
          if (flush_mode_q) begin
            flush_done_d  = 1'b1;
            flush_latch_d = flush_req;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      flush_mode_q  <= 1'b0;
      flush_latch_q <= 1'b0;
      flush_done_q  <= 1'b0;
      padding_q     <= 1'b0;
      issued_q      <= '0;
      accepted_q    <= '0;
      infl_q        <= 1'b0;
      infl_pad_q    <= 1'b0;
      infl_last_q   <= 1'b0;
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      buf_last_q    <= 2'b00;
      buf_pad_q     <= 2'b00;
    end else begin
      state_q       <= state_d;
      flush_mode_q  <= flush_mode_d;
      flush_latch_q <= flush_latch_d;
      flush_done_q  <= flush_done_d;
      padding_q     <= padding_d;
      issued_q      <= issued_d;
      accepted_q    <= accepted_d;
      infl_q        <= infl_d;
      infl_pad_q    <= infl_pad_d;
      infl_last_q   <= infl_last_d;
      count_q       <= count_d;
      if (push) begin
        buf_last_q[wr_ptr_q] <= infl_last_q;
        buf_pad_q[wr_ptr_q]  <= infl_pad_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_buf) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_data_q[wr_ptr_q] <= infl_word;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader (BURST_LEN=4) against a behavioural simple_fifo model.
module tb_fifo_burst_reader;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty, fifo_almost_empty;
  logic       flush_req, flush_done;
  logic       m_tvalid, m_tready;
  logic [7:0] m_tdata;
  logic       m_tlast, m_tpad, busy;

  logic       wr_en;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;

  fifo_burst_reader #(
    .DATA_WIDTH(8),
    .BURST_LEN (BL),
    .CNT_WIDTH (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_empty       (fifo_empty),
    .fifo_almost_empty(fifo_almost_empty),
    .flush_req        (flush_req),
    .flush_done       (flush_done),
    .m_tvalid         (m_tvalid),
    .m_tready         (m_tready),
    .m_tdata          (m_tdata),
    .m_tlast          (m_tlast),
    .m_tpad           (m_tpad),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // simple_fifo model: registered read data, almost_empty threshold BL-1.
  logic [7:0] mem [64];
  logic [5:0] wp, rp;
  int cnt = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int bad_rd = 0;

  assign fifo_empty        = (cnt == 0);
  assign fifo_almost_empty = (cnt <= BL - 1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= 0;
      fifo_rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 6'd1;
      end
      if (fifo_rd_en) begin
        fifo_rd_data <= mem[rp];
        rp <= rp + 6'd1;
        rd_pulses <= rd_pulses + 1;
        if (cnt == 0) bad_rd <= bad_rd + 1;
      end
      cnt <= cnt + (wr_en ? 1 : 0) - (fifo_rd_en ? 1 : 0);
    end
  end

  // Accepted-beat monitor: {pad, last, data}.
  logic [9:0] beat_q[$];
  int         beat_cyc[$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      beat_q.push_back({m_tpad, m_tlast, m_tdata});
      beat_cyc.push_back(cyc);
    end
    if (!rst && flush_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic run_idle(input string tag, input int target);
    logic ok;
    ok = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 300; i++) begin
      if (beat_q.size() >= target && !busy && !m_tvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_complete"}, 32'(ok), 32'd1);
  endtask

  task automatic check_normal(input string tag, input int base, input logic [7:0] d0,
                              input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), 32'(beat_q[base+i]),
            32'({1'b0, (i % BL) == BL - 1, d0 + 8'(i)}));
  endtask

  int base_b, base_rd, base_done, c0;
  logic [7:0] held;
  logic [3:0] pat;

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    flush_req = 1'b0;
    m_tready = 1'b0;
    tick();
    tick();
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_tdata", 32'(m_tdata), 0);
    check("rst_tlast", 32'(m_tlast), 0);
    check("rst_tpad", 32'(m_tpad), 0);
    check("rst_flush_done", 32'(flush_done), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // Single burst, full throughput.
    base_b = beat_q.size();
    base_rd = rd_pulses;
    m_tready = 1'b1;
    write_words(8'h10, 4);
    c0 = cyc;
    run_idle("t1", base_b + 4);
    check("t1_count", 32'(beat_q.size() - base_b), 4);
    check_normal("t1", base_b, 8'h10, 4);
    check("t1_latency", 32'(beat_cyc[base_b] - c0), 2);
    for (int i = 1; i < 4; i++)
      check($sformatf("t1_consec%0d", i), 32'(beat_cyc[base_b+i] - beat_cyc[base_b+i-1]), 1);
    check("t1_rd_pulses", 32'(rd_pulses - base_rd), 4);
    check("t1_busy", 32'(busy), 0);

    // Two bursts with a 1,0,0,1 ready pattern.
    base_b = beat_q.size();
    base_rd = rd_pulses;
    m_tready = 1'b0;
    write_words(8'h20, 8);
    pat = 4'b1001;
    c0 = 0;
    for (int i = 0; i < 400; i++) begin
      m_tready = pat[3 - (i % 4)];
      tick();
      if (beat_q.size() >= base_b + 8 && !busy && !m_tvalid) begin
        c0 = 1;
        break;
      end
    end
    check("t2_complete", 32'(c0), 1);
    check("t2_count", 32'(beat_q.size() - base_b), 8);
    check_normal("t2", base_b, 8'h20, 8);
    check("t2_rd_pulses", 32'(rd_pulses - base_rd), 8);

    // Partial burst waits; flush pads the tail.
    m_tready = 1'b1;
    base_b = beat_q.size();
    base_rd = rd_pulses;
    base_done = done_cnt;
    write_words(8'h30, 3);
    repeat (20) tick();
    check("t3_no_reads", 32'(rd_pulses - base_rd), 0);
    check("t3_idle", 32'(busy), 0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    run_idle("t3", base_b + 4);
    repeat (3) tick();
    check("t3_count", 32'(beat_q.size() - base_b), 4);
    check("t3_beat0", 32'(beat_q[base_b]), 32'h030);
    check("t3_beat1", 32'(beat_q[base_b+1]), 32'h031);
    check("t3_beat2", 32'(beat_q[base_b+2]), 32'h032);
    check("t3_pad", 32'(beat_q[base_b+3]), 32'h300);
    check("t3_done", 32'(done_cnt - base_done), 1);
    check("t3_rd_pulses", 32'(rd_pulses - base_rd), 3);

    // Flush with the FIFO empty.
    base_b = beat_q.size();
    base_rd = rd_pulses;
    base_done = done_cnt;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("t4_done_early", 32'(flush_done), 0);
    tick();
    check("t4_done_pulse", 32'(flush_done), 1);
    check("t4_tvalid", 32'(m_tvalid), 0);
    tick();
    check("t4_done_clear", 32'(flush_done), 0);
    repeat (5) tick();
    check("t4_done_once", 32'(done_cnt - base_done), 1);
    check("t4_no_beats", 32'(beat_q.size() - base_b), 0);
    check("t4_no_reads", 32'(rd_pulses - base_rd), 0);

    // Back-pressure holds the head stable and caps reads at two.
    base_b = beat_q.size();
    base_rd = rd_pulses;
    m_tready = 1'b0;
    write_words(8'h50, 4);
    repeat (8) tick();
    check("t5_reads_capped", 32'(rd_pulses - base_rd), 2);
    check("t5_tvalid", 32'(m_tvalid), 1);
    check("t5_tdata", 32'(m_tdata), 32'h50);
    repeat (3) tick();
    held = m_tdata;
    check("t5_stable", 32'(held), 32'h50);
    check("t5_tlast", 32'(m_tlast), 0);
    m_tready = 1'b1;
    run_idle("t5", base_b + 4);
    check("t5_count", 32'(beat_q.size() - base_b), 4);
    check_normal("t5", base_b, 8'h50, 4);

    // Reset mid-burst, then a clean burst.
    base_b = beat_q.size();
    write_words(8'h60, 4);
    c0 = 0;
    for (int i = 0; i < 50; i++) begin
      if (beat_q.size() >= base_b + 2) begin
        c0 = 1;
        break;
      end
      tick();
    end
    check("t6_two_beats", 32'(c0), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_tvalid", 32'(m_tvalid), 0);
    check("t6_busy", 32'(busy), 0);
    check_normal("t6a", base_b, 8'h60, 2);
    tick();
    base_b = beat_q.size();
    base_rd = rd_pulses;
    write_words(8'h40, 4);
    run_idle("t6", base_b + 4);
    check("t6_count", 32'(beat_q.size() - base_b), 4);
    check_normal("t6", base_b, 8'h40, 4);
    check("t6_rd_pulses", 32'(rd_pulses - base_rd), 4);

    check("rd_while_empty", 32'(bad_rd), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side controller for one simple_fifo instance.
- Waits until the FIFO holds at least one full burst, then drains exactly BURST_LEN words onto an AXI4-Stream master with m_tlast on the final beat.
- Absorbs the FIFO's 1-cycle registered read latency with an internal 2-entry output buffer, so downstream back-pressure never loses data.
- A flush request drains a partial tail burst, zero-padded to BURST_LEN and marked by m_tpad. Used in front of the frame-writer DMA.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and m_tdata.
- BURST_LEN, 16, beats per burst; legal range 2..256. The FIFO instance must use ALMOST_EMPTY_TH = BURST_LEN-1.
- CNT_WIDTH, 8, width of internal beat counters; must satisfy 2^CNT_WIDTH >= BURST_LEN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fifo_rd_en  out  1  read strobe to simple_fifo rd_en.
- fifo_rd_data  in  DATA_WIDTH  simple_fifo rd_data; valid the cycle after a read is issued.
- fifo_empty  in  1  simple_fifo empty.
- fifo_almost_empty  in  1  simple_fifo almost_empty; 0 means the FIFO holds >= BURST_LEN words.
- flush_req  in  1  single-cycle pulse; latched internally.
- flush_done  out  1  single-cycle pulse when a flush completes.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tdata  out  DATA_WIDTH  stream data.
- m_tlast  out  1  last beat of a burst.
- m_tpad  out  1  beat is zero padding, not FIFO data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; issue and accept counters = 0; buffer emptied; flush latch cleared.
  - Outputs: fifo_rd_en=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tpad=0, flush_done=0, busy=0.
  - Reset mid-burst discards in-flight data. A read strobe issued in the reset cycle is ignored; no beat is emitted for it.
- flush latch: set by flush_req; cleared when flush_done pulses. flush_req during a normal burst is held until that burst completes.
- State IDLE:
  - If fifo_almost_empty=0 -> BURST (normal mode). Normal mode has priority over a pending flush.
  - Else if flush latched and fifo_empty=0 -> BURST (flush mode).
  - Else if flush latched and fifo_empty=1 -> pulse flush_done next cycle and stay in IDLE; no beats are sent.
- State BURST:
  - fifo_rd_en = (issued < BURST_LEN) & ~fifo_empty & (buffer occupancy + reads in flight < 2). The output is combinational from registered state.
  - Each read's data is captured into the buffer on the following edge, tagged with tpad=0 and tlast=(beat index == BURST_LEN-1).
  - Normal mode with fifo_empty=1: stall. No reads and no padding.
  - Flush mode with fifo_empty=1 and issued < BURST_LEN:
    - Inject one pad beat per cycle into the buffer (data 0, tpad=1), subject to the same space rule.
    - A pad beat counts as issued.
    - Once padding has started, no further FIFO reads occur in this burst.
  - issued == BURST_LEN -> DRAIN.
- State DRAIN:
  - Wait until all BURST_LEN beats are accepted (m_tvalid & m_tready), then -> IDLE.
  - In flush mode, also pulse flush_done for one cycle on that transition.
- Output stream:
  - m_tvalid = buffer non-empty. The head entry drives m_tdata, m_tlast, and m_tpad.
  - Signals stay stable while m_tvalid & ~m_tready.
  - Sustained throughput is 1 beat/clk when m_tready=1.
- Latency: first m_tvalid appears 2 cycles after fifo_almost_empty falls while in IDLE (1 cycle IDLE->BURST, 1 cycle read latency).
- Counters:
  - issued and accepted are CNT_WIDTH bits and are cleared on entry to BURST.
  - Beat index equals the issued count at capture time; it never wraps within a burst.
- This block is the only reader of the FIFO. It never asserts fifo_rd_en while fifo_empty=1.

Test Plan:
- BURST_LEN=4, DATA_WIDTH=8. Write 0x10..0x13 into the FIFO, m_tready=1 -> beats 0x10,0x11,0x12,0x13 on consecutive cycles; m_tlast only on 0x13; m_tpad=0 throughout; busy returns to 0.
- Write 0x20..0x27 (8 words), m_tready toggling 1,0,0,1 repeatedly -> two bursts in order, no duplicated or dropped beats, m_tlast on 0x23 and 0x27, exactly 8 fifo_rd_en pulses.
- Write 3 words 0x30..0x32 and wait 20 cycles -> no reads, busy=0. Then pulse flush_req -> beats 0x30,0x31,0x32 (tpad=0), then 0x00 (tpad=1, tlast=1), then one flush_done pulse.
- Pulse flush_req with the FIFO empty -> flush_done pulses 1 cycle later, m_tvalid stays 0, no fifo_rd_en.
- Hold m_tready=0 during a burst -> at most 2 reads are issued; m_tdata stays stable; after release the full burst completes intact.
- Assert rst mid-burst after 2 of 4 beats -> m_tvalid=0 and busy=0 next cycle. After a FIFO reset and 4 new words 0x40..0x43, a clean 4-beat burst follows.
